// File: rtl/button_command_decoder.sv
// Turns per-frame NES button codes into one-cycle Tetris commands.
// Left/Right auto-repeat with DAS then ARR, Down repeats at DROP rate, others fire once.
module button_command_decoder #(
    parameter int DAS_FRAMES  = 16,
    parameter int ARR_FRAMES  = 6,
    parameter int DROP_FRAMES = 2,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       button_valid,
    input  logic [3:0] button_code,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [3:0] held_code
);

    typedef enum logic [2:0] {IDLE, DAS, ARR, DROP, HOLD} state_t;

    localparam logic [CNT_W-1:0] DAS_C  = CNT_W'(DAS_FRAMES);
    localparam logic [CNT_W-1:0] ARR_C  = CNT_W'(ARR_FRAMES);
    localparam logic [CNT_W-1:0] DROP_C = CNT_W'(DROP_FRAMES);

    state_t           state_q, state_d;
    logic [3:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_q, cmd_d;

    logic             fire;
    logic [3:0]       code;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [2:0] map_cmd(input logic [3:0] c);
        case (c)
            4'd1:    map_cmd = 3'd4;
            4'd2:    map_cmd = 3'd5;
            4'd3:    map_cmd = 3'd7;
            4'd4:    map_cmd = 3'd6;
            4'd5:    map_cmd = 3'd3;
            4'd6:    map_cmd = 3'd2;
            4'd8:    map_cmd = 3'd1;
            default: map_cmd = 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            held_code_q <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
        end else begin
            state_q     <= state_d;
            held_code_q <= held_code_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
        end
    end

    // Illegal codes 9..15 behave exactly like "no button".
    assign code    = (button_code > 4'd8) ? 4'd0 : button_code;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        cnt_d       = cnt_q;
        fire        = 1'b0;
        if (!enable) begin
            state_d     = IDLE;
            held_code_d = '0;
            cnt_d       = '0;
        end else if (button_valid) begin
            if (code == 4'd0) begin
                state_d     = IDLE;
                held_code_d = '0;
                cnt_d       = '0;
            end else if (code != held_code_q) begin
                fire        = 1'b1;
                held_code_d = code;
                cnt_d       = '0;
                case (code)
                    4'd7, 4'd8: state_d = DAS;
                    4'd6:       state_d = DROP;
                    default:    state_d = HOLD;
                endcase
            end else begin
                case (state_q)
                    DAS: begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DAS_C) begin
                            fire    = 1'b1;
                            cnt_d   = '0;
                            state_d = ARR;
                        end
                    end
                    ARR, DROP: begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == ((state_q == ARR) ? ARR_C : DROP_C)) begin
                            fire  = 1'b1;
                            cnt_d = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every fire emits the command for the code being tracked after this frame.
    always_comb begin
        cmd_valid_d = fire;
        cmd_d       = cmd_q;
        if (!enable)
            cmd_d = '0;
        else if (fire)
            cmd_d = map_cmd(held_code_d);
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign held_code = held_code_q;

endmodule

// File: tb/tb_button_command_decoder.sv
// Directed-vector bench for button_command_decoder: one poll frame per call, hand-derived expectations.
module tb_button_command_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       button_valid;
    logic [3:0] button_code;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [3:0] held_code;

    int n_checks = 0;
    int n_fail   = 0;

    button_command_decoder #(
        .DAS_FRAMES(16), .ARR_FRAMES(6), .DROP_FRAMES(2), .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .button_valid(button_valid), .button_code(button_code),
        .cmd_valid(cmd_valid), .cmd(cmd), .held_code(held_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One poll frame: strobe on a single cycle, sample the registered result, then
    // confirm the pulse lasts one cycle and cmd keeps its value afterwards.
    task automatic frame(input logic [3:0] c, output logic v, output logic [2:0] cm);
        logic [2:0] c_hold;
        @(negedge clk);
        button_valid = 1'b1;
        button_code  = c;
        @(negedge clk);
        button_valid = 1'b0;
        v  = cmd_valid;
        cm = cmd;
        c_hold = cmd;
        @(negedge clk);
        chk("pulse_width", cmd_valid, 0);
        chk("cmd_hold", cmd, c_hold);
    endtask

    // Runs frames 0..last holding code c; fires expected exactly on frames in fire_at.
    task automatic hold_run(input string tag, input logic [3:0] c, input int last,
                            input int fire_at[$], input logic [2:0] exp_cmd);
        logic v;
        logic [2:0] cm;
        for (int f = 0; f <= last; f++) begin
            logic exp_v;
            exp_v = 1'b0;
            foreach (fire_at[k]) if (fire_at[k] == f) exp_v = 1'b1;
            frame(c, v, cm);
            chk({tag, "_valid"}, v, exp_v);
            if (exp_v) chk({tag, "_cmd"}, cm, exp_cmd);
        end
    endtask

    initial begin
        logic v;
        logic [2:0] cm;
        int fires;

        reset = 1'b1; enable = 1'b1; button_valid = 1'b0; button_code = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_held", held_code, 0);

        // A press fires once, then holding does nothing
        frame(4'd1, v, cm);
        chk("a_valid", v, 1);
        chk("a_cmd", cm, 4);
        chk("a_held", held_code, 1);
        fires = 0;
        for (int f = 0; f < 40; f++) begin
            frame(4'd1, v, cm);
            fires += int'(v);
        end
        chk("a_hold_fires", fires, 0);

        // Left DAS/ARR
        frame(4'd0, v, cm);
        chk("release_valid", v, 0);
        chk("release_held", held_code, 0);
        hold_run("left", 4'd7, 30, '{0, 16, 22, 28}, 3'd0);

        // Down drop rate
        frame(4'd0, v, cm);
        hold_run("down", 4'd6, 6, '{0, 2, 4, 6}, 3'd2);
        chk("down_held", held_code, 6);

        // Left, Left, Right directly; DAS restarts on the Right press
        frame(4'd0, v, cm);
        hold_run("lr_l", 4'd7, 1, '{0}, 3'd0);
        frame(4'd8, v, cm);
        chk("lr_r_valid", v, 1);
        chk("lr_r_cmd", cm, 1);
        chk("lr_r_held", held_code, 8);
        for (int f = 3; f <= 18; f++) begin
            frame(4'd8, v, cm);
            chk("lr_das_valid", v, (f == 18) ? 1 : 0);
            if (f == 18) chk("lr_das_cmd", cm, 1);
        end

        // Illegal code behaves as release
        frame(4'd0, v, cm);
        frame(4'd7, v, cm);
        chk("ill_pre_valid", v, 1);
        frame(4'd12, v, cm);
        chk("ill_valid", v, 0);
        chk("ill_held", held_code, 0);
        frame(4'd7, v, cm);
        chk("ill_next_valid", v, 1);
        chk("ill_next_cmd", cm, 0);
        frame(4'd15, v, cm);
        chk("ill15_held", held_code, 0);

        // Reset colliding with a strobe
        @(negedge clk);
        reset = 1'b1; button_valid = 1'b1; button_code = 4'd4;
        @(negedge clk);
        reset = 1'b0; button_valid = 1'b0;
        chk("rst_coll_valid", cmd_valid, 0);
        chk("rst_coll_held", held_code, 0);
        chk("rst_coll_cmd", cmd, 0);

        // Enable low suppresses; re-enable with Up still held fires hard_drop
        frame(4'd5, v, cm);
        chk("up_pre_valid", v, 1);
        enable = 1'b0;
        fires = 0;
        for (int f = 0; f < 3; f++) begin
            frame(4'd5, v, cm);
            fires += int'(v);
        end
        chk("dis_fires", fires, 0);
        chk("dis_held", held_code, 0);
        chk("dis_cmd", cmd, 0);
        enable = 1'b1;
        frame(4'd5, v, cm);
        chk("reen_valid", v, 1);
        chk("reen_cmd", cm, 3);
        chk("reen_held", held_code, 5);

        // Start and B map correctly
        frame(4'd4, v, cm);
        chk("start_cmd", cm, 6);
        frame(4'd2, v, cm);
        chk("b_cmd", cm, 5);
        frame(4'd3, v, cm);
        chk("sel_cmd", cm, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
